div_cycle: RTL and testbench
============================

DIV_CYCLE -- requirements
Module: div_cycle

Interface
REQ-001 SHALL have parameter DIV_WIDTH, default 32, giving the operand and result width in bits.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-004 SHALL have port start, input, 1, a request to begin a division, sampled on the rising edge.
REQ-005 SHALL have port cancel, input, 1, which aborts any operation in progress (pipeline flush or exception).
REQ-006 SHALL have port is_signed, input, 1, selecting DIV (1) or DIVU (0), sampled with start.
REQ-007 SHALL have port dividend, input, DIV_WIDTH, the rs operand, sampled with start.
REQ-008 SHALL have port divisor, input, DIV_WIDTH, the rt operand, sampled with start.
REQ-009 SHALL have port busy, output, 1, high while in CALC or FIX; the EX stage stalls on it.
REQ-010 SHALL have port done, output, 1, a one-cycle pulse marking quotient and remainder valid for the HI/LO write.
REQ-011 SHALL have port quotient, output, DIV_WIDTH, the LO value.
REQ-012 SHALL have port remainder, output, DIV_WIDTH, the HI value.

Function
REQ-013 SHALL implement the FSM states IDLE, CALC, FIX and DONE.
REQ-014 In IDLE, start=1 and cancel=0 at an edge SHALL capture |dividend| and |divisor| (unsigned when is_signed=0) plus the two operand signs, clear the 5-bit iteration counter, and enter CALC.
REQ-015 CALC SHALL perform one restoring shift-subtract step per edge, producing one quotient bit per step, for exactly 32 edges; counter value 31 SHALL transition to FIX.
REQ-016 FIX SHALL apply sign correction, register quotient and remainder, and enter DONE after one edge.
REQ-017 Signed sign rules: the quotient SHALL be negative when the operand signs differ; the remainder SHALL take the sign of the dividend; both SHALL be truncated toward zero.
REQ-018 In DONE, done SHALL equal 1; the next edge SHALL enter CALC if start=1 and cancel=0 (back-to-back), otherwise IDLE.
REQ-019 Latency: for start sampled at edge k, done SHALL be high in the cycle between edges k+33 and k+34; this latency is fixed and independent of operand values.
REQ-020 start while in CALC or FIX SHALL be ignored.
REQ-021 cancel=1 in any state SHALL force IDLE at the next edge with no done pulse; cancel SHALL win over a simultaneous start.
REQ-022 A divisor of zero SHALL yield quotient=all-ones and remainder=dividend (raw input bits), for both signed and unsigned, with normal latency.
REQ-023 Signed 0x80000000 / 0xFFFFFFFF SHALL yield quotient=0x80000000 and remainder=0 with no exception indication.
REQ-024 quotient and remainder SHALL hold their last values in every state except FIX, including after cancel.

Reset
REQ-025 rst_n low SHALL immediately force IDLE, busy=0, done=0, quotient=0, remainder=0, counter=0 and clear the internal partial remainder, regardless of clk.
REQ-026 Reset asserted during CALC or FIX SHALL discard the operation; after release, the first start SHALL behave as from a fresh IDLE.

Structure
REQ-027 The state encodings and DIV_WIDTH default SHALL live in the shared CPU defines header used by the EX-stage units, alongside the multiplier constants.
REQ-028 One combinational sub-module, div_step, SHALL implement a single restoring iteration: {partial remainder, dividend shift} in, {next remainder, quotient bit} out.

Verification
REQ-029 DIVU 100 / 7 -> done 33 cycles after the start edge; quotient=14, remainder=2; busy high for exactly 33 cycles.
REQ-030 DIV -7 / 2 -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1); DIV 7 / -2 -> quotient=-3, remainder=1.
REQ-031 DIV 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0; DIVU 5 / 0 -> quotient=0xFFFFFFFF, remainder=5.
REQ-032 Start a division, then assert cancel at CALC count 10 -> IDLE next cycle, no done pulse, outputs unchanged; a new start completes correctly.
REQ-033 Hold start high during the DONE cycle with new operands (9/4) -> the first result is valid in that cycle; the second result (2, 1) is valid 33 cycles later.
REQ-034 Pulse rst_n low mid-CALC, asynchronously to clk -> outputs are 0 immediately; a subsequent DIVU 0xFFFFFFFF / 1 yields 0xFFFFFFFF, 0.

Source files
------------

// File: rtl/div_cycle_pkg.sv
// rtl/div_cycle_pkg.sv - shared EX-stage constants: divider states/width, multiplier constants
package div_cycle_pkg;

    localparam int DIV_WIDTH_DEF = 32;
    localparam int MUL_WIDTH_DEF = 32;
    localparam int MUL_LATENCY   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring shift-subtract iteration
module div_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem_i,
    input  logic         dvd_bit_i,
    input  logic [W-1:0] divisor_i,
    output logic [W-1:0] rem_o,
    output logic         q_bit_o
);

    logic [W:0]   shifted;
    logic [W-1:0] diff;

    assign shifted = {rem_i, dvd_bit_i};
    // When the subtract succeeds the result is below divisor, so W-bit wraparound is exact.
    assign diff    = shifted[W-1:0] - divisor_i;
    assign q_bit_o = (shifted >= {1'b0, divisor_i});
    assign rem_o   = q_bit_o ? diff : shifted[W-1:0];

endmodule

// File: rtl/div_cycle.sv
// rtl/div_cycle.sv - fixed-latency multicycle DIV/DIVU unit for the EX stage
module div_cycle
    import div_cycle_pkg::*;
#(
    parameter int DIV_WIDTH = DIV_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 cancel,
    input  logic                 is_signed,
    input  logic [DIV_WIDTH-1:0] dividend,
    input  logic [DIV_WIDTH-1:0] divisor,
    output logic                 busy,
    output logic                 done,
    output logic [DIV_WIDTH-1:0] quotient,
    output logic [DIV_WIDTH-1:0] remainder
);

    localparam int W  = DIV_WIDTH;
    localparam int CW = $clog2(W);

    div_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  rem_q, rem_d;
    logic [W-1:0]  dvd_q, dvd_d;
    logic [W-1:0]  dsr_q, dsr_d;
    logic          sdvd_q, sdvd_d;
    logic          sdsr_q, sdsr_d;
    logic          dzero_q, dzero_d;
    logic [W-1:0]  quot_q, quot_d;
    logic [W-1:0]  remo_q, remo_d;

    logic [W-1:0]  abs_dvd, abs_dsr;
    logic [W-1:0]  step_rem;
    logic          step_q;

    assign abs_dvd = (is_signed && dividend[W-1]) ? -dividend : dividend;
    assign abs_dsr = (is_signed && divisor[W-1])  ? -divisor  : divisor;

    // dvd_q doubles as the quotient accumulator: dividend bits shift out, quotient bits shift in.
    div_step #(.W(W)) u_step (
        .rem_i    (rem_q),
        .dvd_bit_i(dvd_q[W-1]),
        .divisor_i(dsr_q),
        .rem_o    (step_rem),
        .q_bit_o  (step_q)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        sdvd_d  = sdvd_q;
        sdsr_d  = sdsr_q;
        dzero_d = dzero_q;
        quot_d  = quot_q;
        remo_d  = remo_q;

        if ((state_q == IDLE || state_q == DONE) && start && !cancel) begin
            state_d = CALC;
            cnt_d   = '0;
            rem_d   = '0;
            dvd_d   = abs_dvd;
            dsr_d   = abs_dsr;
            sdvd_d  = is_signed & dividend[W-1];
            sdsr_d  = is_signed & divisor[W-1];
            dzero_d = (divisor == '0);
        end else begin
            case (state_q)
                CALC: begin
                    rem_d = step_rem;
                    dvd_d = {dvd_q[W-2:0], step_q};
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(W - 1)) state_d = FIX;
                end
                FIX: begin
                    quot_d  = dzero_q ? '1 : ((sdvd_q ^ sdsr_q) ? -dvd_q : dvd_q);
                    remo_d  = sdvd_q ? -rem_q : rem_q;
                    state_d = DONE;
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        if (cancel) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            sdvd_q  <= 1'b0;
            sdsr_q  <= 1'b0;
            dzero_q <= 1'b0;
            quot_q  <= '0;
            remo_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            sdvd_q  <= sdvd_d;
            sdsr_q  <= sdsr_d;
            dzero_q <= dzero_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
        end
    end

    assign busy      = (state_q == CALC) || (state_q == FIX);
    assign done      = (state_q == DONE);
    assign quotient  = quot_q;
    assign remainder = remo_q;

endmodule

// File: tb/tb_div_cycle.sv
// tb/tb_div_cycle.sv - self-checking bench for div_cycle against an arithmetic reference model
module tb_div_cycle;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, cancel, is_signed;
    logic [31:0] dividend, divisor;
    logic        busy, done;
    logic [31:0] quotient, remainder;

    int tests = 0;
    int fails = 0;

    div_cycle #(.DIV_WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .cancel   (cancel),
        .is_signed(is_signed),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .quotient (quotient),
        .remainder(remainder)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic s, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
        longint sa, sb, lq, lr;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            lq = sa / sb;
            lr = sa % sb;
            q  = lq[31:0];
            r  = lr[31:0];
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
            lq = sa / sb;
            lr = sa % sb;
            q  = lq[31:0];
            r  = lr[31:0];
        end
    endfunction

    // Called at a negedge; returns at the negedge just after the start edge.
    task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b);
        start     = 1'b1;
        is_signed = s;
        dividend  = a;
        divisor   = b;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
    endtask

    task automatic wait_done(input string tag, input logic [31:0] eq, input logic [31:0] er);
        int n  = 0;
        int bc = 0;
        while (done !== 1'b1 && n < 40) begin
            if (busy === 1'b1) bc++;
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, n, 33);
        chk({tag, "_busy_cycles"}, bc, 33);
        chk({tag, "_busy_at_done"}, busy, 1'b0);
        chk({tag, "_quot"}, quotient, eq);
        chk({tag, "_rem"}, remainder, er);
    endtask

    task automatic run(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eq, er;
        model(s, a, b, eq, er);
        launch(s, a, b);
        wait_done(tag, eq, er);
        @(negedge clk);
        chk({tag, "_done_pulse"}, done, 1'b0);
        chk({tag, "_hold_quot"}, quotient, eq);
    endtask

    initial begin
        logic [31:0] eq, er, pq, pr, a, b;
        logic        s;
        int          seen;

        rst_n = 1'b0; start = 1'b0; cancel = 1'b0; is_signed = 1'b0;
        dividend = '0; divisor = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_quot", quotient, 32'd0);
        chk("rst_rem", remainder, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run("divu_100_7", 1'b0, 32'd100, 32'd7);
        chk("divu_100_7_q14", quotient, 32'd14);
        run("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        chk("div_m7_2_q", quotient, 32'hFFFF_FFFD);
        chk("div_m7_2_r", remainder, 32'hFFFF_FFFF);
        run("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE);
        chk("div_7_m2_r", remainder, 32'd1);
        run("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_ovf_q", quotient, 32'h8000_0000);
        chk("div_ovf_r", remainder, 32'd0);
        run("divu_5_0", 1'b0, 32'd5, 32'd0);
        chk("divu_5_0_q", quotient, 32'hFFFF_FFFF);
        chk("divu_5_0_r", remainder, 32'd5);
        run("div_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0);
        chk("div_m5_0_r", remainder, 32'hFFFF_FFFB);
        model(1'b1, 32'hFFFF_FFFB, 32'd0, pq, pr);

        // Cancel while the iteration counter reads 10.
        launch(1'b0, 32'd1234, 32'd5);
        repeat (10) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel_busy", busy, 1'b0);
        chk("cancel_done", done, 1'b0);
        chk("cancel_quot", quotient, pq);
        chk("cancel_rem", remainder, pr);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) seen++;
            @(negedge clk);
        end
        chk("cancel_no_done", seen, 0);
        run("after_cancel", 1'b0, 32'd1000, 32'd3);

        // Cancel beats a simultaneous start.
        start = 1'b1; cancel = 1'b1; dividend = 32'd8; divisor = 32'd2;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        chk("cancel_wins_busy", busy, 1'b0);

        // Start held during DONE launches a back-to-back division.
        model(1'b0, 32'd50, 32'd7, eq, er);
        launch(1'b0, 32'd50, 32'd7);
        wait_done("b2b_first", eq, er);
        launch(1'b0, 32'd9, 32'd4);
        wait_done("b2b_second", 32'd2, 32'd1);
        @(negedge clk);

        // Asynchronous reset in the middle of CALC.
        launch(1'b1, 32'h1234_5678, 32'd3);
        repeat (12) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_done", done, 1'b0);
        chk("arst_quot", quotient, 32'd0);
        chk("arst_rem", remainder, 32'd0);
        #3 rst_n = 1'b1;
        @(negedge clk);
        run("after_rst", 1'b0, 32'hFFFF_FFFF, 32'd1);
        chk("after_rst_r0", remainder, 32'd0);

        for (int i = 0; i < 24; i++) begin
            s = 1'(($urandom_range(0, 1)));
            a = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : 32'($urandom);
            case ($urandom_range(0, 3))
                0:       b = 32'($urandom);
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'd0;
                default: b = -32'($urandom_range(1, 9));
            endcase
            run($sformatf("rand%0d", i), s, a, b);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
